// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the core pipeline (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
   // Decode-stage instruction fields
   logic [3:0] RA1D;
   logic [3:0] RA2D;
   logic       useRA1D;
   logic       useRA2D;
   logic [3:0] WA3D;
   logic       regWriteD;
   logic       memToRegD;
   logic       memReqD;
   // Branch resolution from Execute
   logic       branchTakenE;
   // Pipeline-register controls
   logic       stallF;
   logic       stallD;
   logic       stallE;
   logic       stallM;
   logic       flushD;
   logic       flushE;
   logic       flushW;
   // Execute-stage ALU operand selects
   logic [1:0] fwdAE;
   logic [1:0] fwdBE;

   modport master (
      output RA1D, RA2D, useRA1D, useRA2D, WA3D, regWriteD, memToRegD, memReqD,
      output branchTakenE,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE
   );

   modport slave (
      input  RA1D, RA2D, useRA1D, useRA2D, WA3D, regWriteD, memToRegD, memReqD,
      input  branchTakenE,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: keeps a shadow copy of the
// register/control fields in E, M and W, resolves load-use and taken-branch hazards,
// holds the pipe while a data-memory access occupies M, and selects ALU forwarding.
module pipe_hazard_ctrl #(
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);

   // A single-cycle memory never waits; the counter is kept one bit wide in that case.
   localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int CNT_LOAD = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
   localparam bit MULTI    = (MEM_LAT > 1);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // E-stage shadow
   logic [3:0] RA1E_q, RA1E_d;
   logic [3:0] RA2E_q, RA2E_d;
   logic [3:0] WA3E_q, WA3E_d;
   logic       regWriteE_q, regWriteE_d;
   logic       memToRegE_q, memToRegE_d;
   logic       memReqE_q, memReqE_d;
   // M-stage shadow
   logic [3:0] WA3M_q, WA3M_d;
   logic       regWriteM_q, regWriteM_d;
   logic       memReqM_q, memReqM_d;
   // W-stage shadow
   logic [3:0] WA3W_q, WA3W_d;
   logic       regWriteW_q, regWriteW_d;

   // Internal hazard terms
   logic mw;        // memory wait: whole front of the pipe frozen
   logic br;        // taken branch acting this cycle
   logic lu_raw;    // load-use dependency seen between D and E
   logic lu;        // load-use after higher-priority hazards are removed
   logic flushE_c;  // E-register bubble, before reset gating

   // Forwarding priority: the younger M result wins over W.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                          input logic       wr_m,
                                          input logic [3:0] wa_m,
                                          input logic       wr_w,
                                          input logic [3:0] wa_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (wa_m == ra)) begin
         sel = 2'b10;
      end else if (wr_w && (wa_w == ra)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Memory-wait FSM: next state, counter and the wait flag.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mw      = 1'b0;
      case (state_q)
         RUN: begin
            if (memReqM_q && MULTI) begin
               mw      = 1'b1;
               state_d = MEM_WAIT;
               cnt_d   = CNT_W'(CNT_LOAD);
            end
         end
         MEM_WAIT: begin
            if (cnt_q != '0) begin
               mw    = 1'b1;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Hazard detection with priority mw > br > lu.
   always_comb begin
      br     = hz.branchTakenE && !mw;
      lu_raw = regWriteE_q && memToRegE_q &&
               ((hz.useRA1D && (hz.RA1D == WA3E_q)) ||
                (hz.useRA2D && (hz.RA2D == WA3E_q)));
      lu       = lu_raw && !mw && !br;
      flushE_c = br || lu;
   end

   // Output drive; everything is held quiet while reset is asserted.
   always_comb begin
      hz.stallF = 1'b0;
      hz.stallD = 1'b0;
      hz.stallE = 1'b0;
      hz.stallM = 1'b0;
      hz.flushD = 1'b0;
      hz.flushE = 1'b0;
      hz.flushW = 1'b0;
      hz.fwdAE  = 2'b00;
      hz.fwdBE  = 2'b00;
      if (rst) begin
         hz.stallF = mw || lu;
         hz.stallD = mw || lu;
         hz.stallE = mw;
         hz.stallM = mw;
         hz.flushD = br;
         hz.flushE = flushE_c;
         hz.flushW = mw;
         hz.fwdAE  = fwd_sel(RA1E_q, regWriteM_q, WA3M_q, regWriteW_q, WA3W_q);
         hz.fwdBE  = fwd_sel(RA2E_q, regWriteM_q, WA3M_q, regWriteW_q, WA3W_q);
      end
   end

   // Shadow-pipeline next state; stallE and stallM both equal mw, flushW equals mw.
   always_comb begin
      RA1E_d      = RA1E_q;
      RA2E_d      = RA2E_q;
      WA3E_d      = WA3E_q;
      regWriteE_d = regWriteE_q;
      memToRegE_d = memToRegE_q;
      memReqE_d   = memReqE_q;
      WA3M_d      = WA3M_q;
      regWriteM_d = regWriteM_q;
      memReqM_d   = memReqM_q;
      WA3W_d      = WA3W_q;
      regWriteW_d = regWriteW_q;

      if (!mw) begin
         // E takes the Decode instruction; a bubble keeps the fields but drops the controls.
         RA1E_d = hz.RA1D;
         RA2E_d = hz.RA2D;
         WA3E_d = hz.WA3D;
         if (flushE_c) begin
            regWriteE_d = 1'b0;
            memToRegE_d = 1'b0;
            memReqE_d   = 1'b0;
         end else begin
            regWriteE_d = hz.regWriteD;
            memToRegE_d = hz.memToRegD;
            memReqE_d   = hz.memReqD;
         end
         WA3M_d      = WA3E_q;
         regWriteM_d = regWriteE_q;
         memReqM_d   = memReqE_q;
         WA3W_d      = WA3M_q;
         regWriteW_d = regWriteM_q;
      end else begin
         // M is frozen, so W receives a bubble.
         WA3W_d      = 4'd0;
         regWriteW_d = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Shadow pipeline registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RA1E_q      <= 4'd0;
         RA2E_q      <= 4'd0;
         WA3E_q      <= 4'd0;
         regWriteE_q <= 1'b0;
         memToRegE_q <= 1'b0;
         memReqE_q   <= 1'b0;
         WA3M_q      <= 4'd0;
         regWriteM_q <= 1'b0;
         memReqM_q   <= 1'b0;
         WA3W_q      <= 4'd0;
         regWriteW_q <= 1'b0;
      end else begin
         RA1E_q      <= RA1E_d;
         RA2E_q      <= RA2E_d;
         WA3E_q      <= WA3E_d;
         regWriteE_q <= regWriteE_d;
         memToRegE_q <= memToRegE_d;
         memReqE_q   <= memReqE_d;
         WA3M_q      <= WA3M_d;
         regWriteM_q <= regWriteM_d;
         memReqM_q   <= memReqM_d;
         WA3W_q      <= WA3W_d;
         regWriteW_q <= regWriteW_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (memory latency 3 and 4) share one stimulus
// stream and are compared every cycle against an instruction-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int LAT0 = 3;
   localparam int LAT1 = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if if0 ();
   pipe_hazard_ctrl_if if1 ();

   pipe_hazard_ctrl #(.MEM_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .hz(if0));
   pipe_hazard_ctrl #(.MEM_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .hz(if1));

   // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwdAE, fwdBE}
   logic [10:0] out0, out1;
   assign out0 = {if0.stallF, if0.stallD, if0.stallE, if0.stallM,
                  if0.flushD, if0.flushE, if0.flushW, if0.fwdAE, if0.fwdBE};
   assign out1 = {if1.stallF, if1.stallD, if1.stallE, if1.stallM,
                  if1.flushD, if1.flushE, if1.flushW, if1.fwdAE, if1.fwdBE};

   typedef struct packed {
      logic [3:0] ra1;
      logic       use1;
      logic [3:0] ra2;
      logic       use2;
      logic [3:0] wa3;
      logic       rw;
      logic       ld;
      logic       mreq;
      logic       bt;
   } din_t;

   // Instruction occupying each stage, plus how long the M occupant has been there.
   typedef struct packed {
      logic [3:0] ra1e;
      logic [3:0] ra2e;
      logic [3:0] wa3e;
      logic       rwe;
      logic       lde;
      logic       mreqe;
      logic [3:0] wa3m;
      logic       rwm;
      logic       mreqm;
      logic [3:0] wa3w;
      logic       rww;
      logic [7:0] age;
   } mdl_t;

   mdl_t mdl [2];
   int   n_checks = 0;
   int   n_pass   = 0;

   din_t NOP;
   din_t STR;
   din_t BRT;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic din_t mk(input int ra1, input int u1, input int ra2, input int u2,
                               input int wa3, input int rw, input int ld, input int mreq,
                               input int bt);
      din_t d;
      d.ra1  = 4'(ra1);
      d.use1 = 1'(u1);
      d.ra2  = 4'(ra2);
      d.use2 = 1'(u2);
      d.wa3  = 4'(wa3);
      d.rw   = 1'(rw);
      d.ld   = 1'(ld);
      d.mreq = 1'(mreq);
      d.bt   = 1'(bt);
      return d;
   endfunction

   function automatic logic [1:0] fwd_of(input logic [3:0] ra, input mdl_t m);
      if (m.rwm && m.wa3m == ra) return 2'b10;
      if (m.rww && m.wa3w == ra) return 2'b01;
      return 2'b00;
   endfunction

   // Expected outputs for this cycle, then advance the model to the next edge.
   task automatic check_model(input int k, input logic [10:0] act);
      mdl_t        m;
      mdl_t        n;
      int          lat;
      logic        mw, lu, bt;
      logic        sF, sD, sE, sM, fD, fE, fW;
      logic [10:0] exp;
      lat = (k == 0) ? LAT0 : LAT1;
      m   = mdl[k];
      if (!rst) begin
         exp = '0;
         n   = '0;
      end else begin
         mw = m.mreqm && (int'(m.age) < lat - 1);
         bt = if0.branchTakenE;
         lu = m.rwe && m.lde && ((if0.useRA1D && if0.RA1D == m.wa3e) ||
                                 (if0.useRA2D && if0.RA2D == m.wa3e));
         {sF, sD, sE, sM, fD, fE, fW} = '0;
         if (mw) begin
            {sF, sD, sE, sM, fW} = 5'b11111;
         end else if (bt) begin
            {fD, fE} = 2'b11;
         end else if (lu) begin
            {sF, sD, fE} = 3'b111;
         end
         exp = {sF, sD, sE, sM, fD, fE, fW, fwd_of(m.ra1e, m), fwd_of(m.ra2e, m)};
         n = m;
         if (mw) begin
            n.wa3w = 4'd0;
            n.rww  = 1'b0;
            n.age  = m.age + 8'd1;
         end else begin
            n.wa3w  = m.wa3m;
            n.rww   = m.rwm;
            n.wa3m  = m.wa3e;
            n.rwm   = m.rwe;
            n.mreqm = m.mreqe;
            n.age   = 8'd0;
            n.ra1e  = if0.RA1D;
            n.ra2e  = if0.RA2D;
            n.wa3e  = if0.WA3D;
            n.rwe   = fE ? 1'b0 : if0.regWriteD;
            n.lde   = fE ? 1'b0 : if0.memToRegD;
            n.mreqe = fE ? 1'b0 : if0.memReqD;
         end
      end
      mdl[k] = n;
      chk((k == 0) ? "model_lat3" : "model_lat4", {21'd0, act}, {21'd0, exp});
   endtask

   // Per-cycle comparison against the model.
   initial begin
      mdl[0] = '0;
      mdl[1] = '0;
      forever begin
         @(negedge clk);
         check_model(0, out0);
         check_model(1, out1);
      end
   end

   task automatic drive(input din_t d);
      if0.RA1D = d.ra1;  if0.useRA1D = d.use1; if0.RA2D = d.ra2; if0.useRA2D = d.use2;
      if0.WA3D = d.wa3;  if0.regWriteD = d.rw; if0.memToRegD = d.ld; if0.memReqD = d.mreq;
      if0.branchTakenE = d.bt;
      if1.RA1D = d.ra1;  if1.useRA1D = d.use1; if1.RA2D = d.ra2; if1.useRA2D = d.use2;
      if1.WA3D = d.wa3;  if1.regWriteD = d.rw; if1.memToRegD = d.ld; if1.memReqD = d.mreq;
      if1.branchTakenE = d.bt;
   endtask

   // One cycle: apply inputs just after the rising edge, return just after the falling edge.
   task automatic cycr(input logic r, input din_t d);
      @(posedge clk);
      #1;
      rst = r;
      drive(d);
      @(negedge clk);
      #1;
   endtask

   task automatic cyc(input din_t d);
      cycr(1'b1, d);
   endtask

   initial begin
      logic [17:0] r;
      din_t        d;
      NOP = '0;
      STR = mk(1, 0, 2, 0, 0, 0, 0, 1, 0);
      BRT = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(NOP);

      // Reset with random inputs and a taken branch presented
      for (int i = 0; i < 4; i++) begin
         r = 18'($urandom);
         d = din_t'(r);
         d.bt = 1'b1;
         cycr(1'b0, d);
         chk("rst_out_lat3", {21'd0, out0}, 32'd0);
         chk("rst_out_lat4", {21'd0, out1}, 32'd0);
      end

      // Forwarding: ADD r1 then SUB r2,r1 -> M forward; with one NOP between -> W forward
      cycr(1'b1, NOP);
      cyc(NOP);
      cyc(mk(5, 1, 6, 1, 1, 1, 0, 0, 0));
      cyc(mk(1, 1, 7, 1, 2, 1, 0, 0, 0));
      cyc(NOP);
      chk("fwdA_from_M", {30'd0, if0.fwdAE}, 32'd2);
      chk("fwdB_none", {30'd0, if0.fwdBE}, 32'd0);
      chk("fwdA_from_M_lat4", {30'd0, if1.fwdAE}, 32'd2);
      cyc(mk(5, 1, 6, 1, 4, 1, 0, 0, 0));
      cyc(NOP);
      cyc(mk(4, 1, 7, 1, 2, 1, 0, 0, 0));
      cyc(NOP);
      chk("fwdA_from_W", {30'd0, if0.fwdAE}, 32'd1);
      cyc(NOP);
      cyc(NOP);

      // Load-use: the load is issued without memReqD so no memory wait overlaps
      cyc(mk(8, 1, 0, 0, 3, 1, 1, 0, 0));
      cyc(mk(3, 1, 9, 1, 4, 1, 0, 0, 0));
      chk("lu_stallF_stallD_flushE", {29'd0, if0.stallF, if0.stallD, if0.flushE}, 32'd7);
      chk("lu_stallE", {31'd0, if0.stallE}, 32'd0);
      chk("lu_stallF_lat4", {31'd0, if1.stallF}, 32'd1);
      cyc(mk(3, 1, 9, 1, 4, 1, 0, 0, 0));
      chk("lu_after_nostall", {30'd0, if0.stallF, if0.flushE}, 32'd0);
      cyc(NOP);
      chk("lu_fwdA_from_W", {30'd0, if0.fwdAE}, 32'd1);
      cyc(NOP);
      cyc(NOP);

      // Unused source never causes a load-use stall
      cyc(mk(8, 1, 0, 0, 3, 1, 1, 0, 0));
      cyc(mk(3, 0, 10, 1, 4, 1, 0, 0, 0));
      chk("unused_src_nostall", {30'd0, if0.stallF, if0.flushE}, 32'd0);
      cyc(NOP);
      cyc(NOP);

      // Taken branch overrides a simultaneous load-use
      cyc(mk(8, 1, 0, 0, 5, 1, 1, 0, 0));
      cyc(mk(5, 1, 0, 0, 6, 1, 0, 0, 1));
      chk("br_flushD_flushE", {30'd0, if0.flushD, if0.flushE}, 32'd3);
      chk("br_no_stall", {30'd0, if0.stallF, if0.stallD}, 32'd0);
      cyc(NOP);
      cyc(NOP);

      // Store in M with a branch held in E for the whole wait
      cyc(STR);
      cyc(NOP);
      cyc(BRT);
      chk("mw1_stalls_lat3", {28'd0, out0[10:7]}, 32'hF);
      chk("mw1_flushW_lat3", {31'd0, if0.flushW}, 32'd1);
      chk("mw1_flushDE_lat3", {30'd0, if0.flushD, if0.flushE}, 32'd0);
      chk("mw1_stalls_lat4", {28'd0, out1[10:7]}, 32'hF);
      cyc(BRT);
      chk("mw2_stalls_lat3", {28'd0, out0[10:7]}, 32'hF);
      chk("mw2_flushDE_lat3", {30'd0, if0.flushD, if0.flushE}, 32'd0);
      chk("mw2_flushW_lat4", {31'd0, if1.flushW}, 32'd1);
      cyc(BRT);
      chk("mw_release_stalls_lat3", {28'd0, out0[10:7]}, 32'h0);
      chk("mw_release_flushW_lat3", {31'd0, if0.flushW}, 32'd0);
      chk("mw_release_br_lat3", {30'd0, if0.flushD, if0.flushE}, 32'd3);
      chk("mw3_stalls_lat4", {28'd0, out1[10:7]}, 32'hF);
      chk("mw3_flushDE_lat4", {30'd0, if1.flushD, if1.flushE}, 32'd0);
      cyc(BRT);
      chk("mw_release_stalls_lat4", {28'd0, out1[10:7]}, 32'h0);
      chk("mw_release_br_lat4", {30'd0, if1.flushD, if1.flushE}, 32'd3);
      cyc(NOP);
      cyc(NOP);
      cyc(NOP);

      // Back-to-back stores: the second retriggers the wait as soon as it enters M
      cyc(STR);
      cyc(STR);
      cyc(NOP);
      cyc(NOP);
      cyc(NOP);
      chk("b2b_gap_lat3", {31'd0, if0.stallM}, 32'd0);
      chk("b2b_wait_lat4", {31'd0, if1.stallM}, 32'd1);
      cyc(NOP);
      chk("b2b_second_lat3", {31'd0, if0.stallM}, 32'd1);
      chk("b2b_gap_lat4", {31'd0, if1.stallM}, 32'd0);
      cyc(NOP);
      chk("b2b_second2_lat3", {31'd0, if0.stallM}, 32'd1);
      chk("b2b_second_lat4", {31'd0, if1.stallM}, 32'd1);
      for (int i = 0; i < 4; i++) cyc(NOP);

      // Reset in the second wait cycle abandons the wait
      cyc(STR);
      cyc(NOP);
      cyc(NOP);
      chk("midrst_pre_lat4", {31'd0, if1.stallM}, 32'd1);
      cycr(1'b0, BRT);
      chk("midrst_out_lat4", {21'd0, out1}, 32'd0);
      chk("midrst_out_lat3", {21'd0, out0}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(NOP);
         chk("post_rst_idle_lat4", {21'd0, out1}, 32'd0);
      end
      cyc(STR);
      cyc(NOP);
      cyc(NOP);
      chk("post_rst_new_store_lat4", {31'd0, if1.stallM}, 32'd1);
      chk("post_rst_new_store_lat3", {31'd0, if0.stallM}, 32'd1);
      for (int i = 0; i < 5; i++) cyc(NOP);

      // Mixed traffic over a small register set
      for (int i = 0; i < 300; i++) begin
         r = 18'($urandom);
         d = din_t'(r);
         d.ra1  = 4'($urandom_range(0, 3));
         d.ra2  = 4'($urandom_range(0, 3));
         d.wa3  = 4'($urandom_range(0, 3));
         d.bt   = ($urandom_range(0, 7) == 0);
         d.mreq = ($urandom_range(0, 4) == 0);
         cyc(d);
      end
      cyc(NOP);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
